// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity-type constants and
// small elaboration-time helpers used by the Tx serializer and Rx checker.
package uart_pkg;

  // Frame-level FSM states, 3-bit encoding shared by Tx and Rx.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Parity selection as carried on par_typ.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Width of a counter that indexes DATA_WIDTH bits; never below one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    if (width <= 32'd1) begin
      cnt_width = 32'd1;
    end else begin
      cnt_width = $clog2(width);
    end
  endfunction

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator for a UART word. Even parity yields a bit
// that makes the total count of ones (data plus parity) even; odd inverts it.
module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  parity
);

  // Reduction XOR of the word, inverted when odd parity is selected.
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] word,
                                       input logic                  typ);
    calc_parity = (^word) ^ (typ == PAR_ODD);
  endfunction

  assign parity = calc_parity(data, par_typ);

endmodule

// File: rtl/uart_tx.sv
// UART transmit serializer: one bit per clock, start / LSB-first data /
// optional parity / stop. tx_out and busy are registered, so every output
// value is computed for the state being entered on the next edge.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int unsigned       CNT_W    = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);

  uart_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   pen_q, pen_d;
  logic                   ptyp_q, ptyp_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   parity_s;

  // Parity is always taken from the latched copy of the word, never p_data.
  uart_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .data    (data_q),
    .par_typ (ptyp_q),
    .parity  (parity_s)
  );

  // Next-state, next-output and datapath update for the frame FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    pen_d   = pen_q;
    ptyp_d  = ptyp_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (data_valid) begin
          state_d = ST_START;
          shift_d = p_data;
          data_d  = p_data;
          pen_d   = par_en;
          ptyp_d  = par_typ;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end
      ST_START: begin
        state_d = ST_DATA;
        cnt_d   = CNT_ZERO;
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1'b1;
        busy_d  = 1'b1;
      end
      ST_DATA: begin
        busy_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          if (pen_q) begin
            state_d = ST_PARITY;
            tx_d    = parity_s;
          end else begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1'b1;
        end
      end
      ST_PARITY: begin
        state_d = ST_STOP;
        tx_d    = 1'b1;
        busy_d  = 1'b1;
      end
      ST_STOP: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; reset aborts any frame at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      shift_q <= {DATA_WIDTH{1'b0}};
      data_q  <= {DATA_WIDTH{1'b0}};
      pen_q   <= 1'b0;
      ptyp_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      pen_q   <= pen_d;
      ptyp_q  <= ptyp_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed, table-driven bench for uart_tx (DATA_WIDTH = 8). Expected frame
// bit patterns are hand-computed; bit j of 'bits' is the line value in the
// j-th cycle after the accepting edge (start bit first, stop bit last).
module tb_uart_tx;

  localparam int W = 8;

  logic         clock;
  logic         reset;
  logic [W-1:0] p_data;
  logic         data_valid;
  logic         par_en;
  logic         par_typ;
  logic         tx_out;
  logic         busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]  data;
    logic        pen;
    logic        ptyp;
    int          len;
    logic [10:0] bits;
    logic        pulse;
  } vec_t;

  vec_t vecs[8];

  uart_tx #(.DATA_WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Sends one vector, scrambles the inputs after acceptance, checks every
  // frame cycle and then three idle cycles.
  task automatic send(input int idx, input vec_t v);
    @(negedge clock);
    p_data = v.data; par_en = v.pen; par_typ = v.ptyp; data_valid = 1'b1;
    @(negedge clock);
    data_valid = 1'b0; p_data = ~v.data; par_en = ~v.pen; par_typ = ~v.ptyp;
    for (int j = 0; j < v.len; j++) begin
      if (j > 0) @(negedge clock);
      chk($sformatf("v%0d tx bit%0d", idx, j), tx_out, v.bits[j]);
      chk($sformatf("v%0d busy bit%0d", idx, j), busy, 1'b1);
      if (v.pulse) begin
        data_valid = (j == 4);
        if (j == 4) p_data = 8'h3C;
      end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk($sformatf("v%0d idle tx %0d", idx, k), tx_out, 1'b1);
      chk($sformatf("v%0d idle busy %0d", idx, k), busy, 1'b0);
    end
  endtask

  initial begin
    logic [9:0] f_a5;
    int         m;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 10, 11'b00_1101001010, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 11, 11'b10101001010, 1'b0};
    vecs[2] = '{8'hA5, 1'b1, 1'b1, 11, 11'b11101001010, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 11, 11'b11000000000, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 1'b0, 11, 11'b10111111110, 1'b0};
    vecs[5] = '{8'h81, 1'b0, 1'b0, 10, 11'b00_1100000010, 1'b1};
    vecs[6] = '{8'h01, 1'b1, 1'b1, 11, 11'b10000000010, 1'b0};
    vecs[7] = '{8'h55, 1'b0, 1'b0, 10, 11'b00_1010101010, 1'b0};

    p_data = 8'h00; data_valid = 1'b0; par_en = 1'b0; par_typ = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("reset tx", tx_out, 1'b1);
    chk("reset busy", busy, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("post-reset tx", tx_out, 1'b1);
    chk("post-reset busy", busy, 1'b0);

    for (int i = 0; i < 7; i++) send(i, vecs[i]);

    // data_valid held high: 10-cycle frames back to back, one idle between.
    f_a5 = 10'b1101001010;
    @(negedge clock);
    p_data = 8'hA5; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
    for (int j = 0; j < 33; j++) begin
      @(negedge clock);
      m = j % 11;
      if (m == 10) begin
        chk($sformatf("held idle tx c%0d", j), tx_out, 1'b1);
        chk($sformatf("held idle busy c%0d", j), busy, 1'b0);
      end else begin
        chk($sformatf("held tx c%0d", j), tx_out, f_a5[m]);
        chk($sformatf("held busy c%0d", j), busy, 1'b1);
      end
      if (j == 32) data_valid = 1'b0;
    end
    @(negedge clock);
    chk("held end tx", tx_out, 1'b1);
    chk("held end busy", busy, 1'b0);

    // Asynchronous reset during data bit 3 of a 0xA5 frame.
    @(negedge clock);
    p_data = 8'hA5; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
    @(negedge clock);
    data_valid = 1'b0;
    chk("abort start bit", tx_out, 1'b0);
    repeat (4) @(negedge clock);
    chk("abort bit3 tx", tx_out, 1'b0);
    chk("abort bit3 busy", busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("abort async tx", tx_out, 1'b1);
    chk("abort async busy", busy, 1'b0);
    @(negedge clock);
    chk("abort held tx", tx_out, 1'b1);
    chk("abort held busy", busy, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    chk("abort release tx", tx_out, 1'b1);
    chk("abort release busy", busy, 1'b0);
    send(7, vecs[7]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmit serializer, the transmit-side counterpart of the UART Rx chain. Accepts a parallel word through a valid/busy handshake. Emits one frame on `tx_out`, one bit per `clock` cycle (clock equals bit rate):
- start bit (0)
- DATA_WIDTH data bits, LSB first
- optional parity bit
- one stop bit (1)

The line idles high between frames.

## Interface
Parameters:
- DATA_WIDTH, 8, payload bits per frame (≥1)

Ports:
- clock  input  1  bit-rate clock, rising-edge active
- reset  input  1  asynchronous, active-low reset
- p_data  input  DATA_WIDTH  parallel payload, sampled on acceptance
- data_valid  input  1  request to send `p_data`
- par_en  input  1  1 = insert parity bit; sampled on acceptance
- par_typ  input  1  0 = even, 1 = odd; sampled on acceptance
- tx_out  output  1  serial line, registered
- busy  output  1  frame in progress, registered

## Operation
- One clock, `clock`. Reset `reset` is asynchronous and active-low.
- While `reset` = 0: state IDLE, `tx_out` = 1, `busy` = 0, bit counter = 0, shift/config registers = 0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE
  - Drives `tx_out` = 1 and `busy` = 0.
  - On an edge with `data_valid` = 1, latches `p_data`, `par_en` and `par_typ`, and goes to START.
- START: drives `tx_out` = 0 and `busy` = 1; goes to DATA with counter = 0.
- DATA
  - Drives `tx_out` = shift_reg[0]; shifts right each cycle.
  - After DATA_WIDTH cycles, goes to PARITY if latched `par_en` = 1, else to STOP.
- PARITY
  - Drives `tx_out` = XOR of the latched data, XOR latched `par_typ`.
  - Even parity makes the total count of 1s in data plus parity even.
  - Goes to STOP.
- STOP: drives `tx_out` = 1 and `busy` = 1; goes to IDLE unconditionally.
- Acceptance happens only in IDLE. `data_valid` in any other state is ignored and never queued.
- `p_data`, `par_en` and `par_typ` may change freely after the accepting edge; the frame uses only the latched values.
- Parity is computed from the latched word, never from the live `p_data`.
- Reset asserted mid-frame aborts the frame immediately, asynchronously:
  - line returns to 1, `busy` = 0;
  - after reset release, the next frame starts cleanly.

## Timing
- Outputs are registered and change only on rising `clock` edges, or asynchronously on reset.
- Accepting edge E (IDLE, `data_valid` = 1): start bit appears on `tx_out` for the cycle after E, and `busy` rises at E.
- Data bit i (0-based) is driven in cycle E+1+i.
- Parity, if enabled, is driven in cycle E+1+DATA_WIDTH.
- Stop bit is driven in the last frame cycle.
- Frame length: 2 + DATA_WIDTH + par_en cycles.
- `busy` falls on the edge that leaves STOP.
- The earliest next acceptance is the following edge, so:
  - the line shows at least one extra idle-high cycle between frames (effectively ≥2 stop bits);
  - with `data_valid` held high, frame period = 3 + DATA_WIDTH + par_en cycles.
- Bit counter width: clog2(DATA_WIDTH), minimum 1; it must not wrap inside DATA.

## Structure
- Shared UART package holds:
  - FSM state encoding constants (3-bit);
  - parity-type constants PAR_EVEN = 0, PAR_ODD = 1, used by both the Tx and Rx parity logic.
- One sub-module is natural: `uart_parity_calc`.
  - Combinational: inputs data (DATA_WIDTH) and par_typ; output parity bit.
  - Reusable by the Rx parity checker.
- The FSM, counter and serializer stay in `uart_tx`.

## Test plan
1. Reset, then 0xA5 with `par_en` = 0, DATA_WIDTH = 8.
   - `tx_out` after acceptance: 0,1,0,1,0,0,1,0,1,1.
   - `busy` is high for exactly 10 cycles, then low.
2. 0xA5, `par_en` = 1:
   - `par_typ` = 0 → parity bit 0 (11-cycle frame);
   - `par_typ` = 1 → parity bit 1.
3. 0x00 with odd parity: 0, eight 0s, 1, 1. Then 0xFF with even parity: 0, eight 1s, 0, 1.
4. Pulse `data_valid` with 0x3C mid-frame while sending 0x81.
   - 0x81 frame completes intact.
   - No second frame follows; the line stays 1 and `busy` = 0.
   - Changing `p_data` during the frame does not alter the transmitted bits.
5. Hold `data_valid` high for 3 frames, no parity:
   - frames start every 11 cycles;
   - each stop bit is followed by exactly one idle-high cycle.
6. Assert `reset` = 0 during data bit 3, asynchronously between edges.
   - `tx_out` goes 1 and `busy` goes 0 immediately.
   - After release, a new 0x55 frame transmits correctly.
